// File: rtl/pc_next_ctrl.sv
// Fetch-stage program counter: prioritised redirect select, sequential step,
// redirect buffering across stalls/halts, and a RUN/HALTED debug state.

module pc_next_ctrl_slot #(
  parameter int NB = 32
) (
  input  logic          i_valid,
  input  logic          i_hi_any,
  input  logic [NB-1:0] i_addr,
  output logic          o_hi_any,
  output logic [NB-1:0] o_addr
);
  // A slot wins only when no higher-priority slot above it requested.
  logic w_take;
  assign w_take   = i_valid & ~i_hi_any;
  assign o_hi_any = i_hi_any | i_valid;
  assign o_addr   = i_addr & {NB{w_take}};
endmodule

module pc_next_ctrl #(
  parameter int                 NB       = 32,
  parameter int                 N_SRC    = 3,
  parameter logic [NB-1:0]      RESET_PC = '0,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_SRC-1:0]      i_redir_valid,
  input  logic [N_SRC*NB-1:0]   i_redir_addr,
  input  logic                  i_stall,
  input  logic                  i_halt,
  output logic [NB-1:0]         o_pc,
  output logic [NB-1:0]         o_pc4,
  output logic                  o_fetch_en,
  output logic                  o_redir_taken,
  output logic                  o_pending,
  output logic                  o_halted
);
  localparam logic [NB-1:0] STEP = NB'(PC_STEP);

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  state_t                    r_state, w_state_nxt;
  logic [NB-1:0]             r_pc, r_pend_addr, w_pc_nxt, w_sel_addr;
  logic                      r_pending, r_redir_taken;
  logic [N_SRC:0]            w_hi;
  logic [N_SRC-1:0][NB-1:0]  w_slot_addr;
  logic                      w_live, w_adv;

  assign w_hi[0] = 1'b0;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    pc_next_ctrl_slot #(.NB(NB)) u_slot (
      .i_valid  (i_redir_valid[k]),
      .i_hi_any (w_hi[k]),
      .i_addr   (i_redir_addr[k*NB +: NB]),
      .o_hi_any (w_hi[k+1]),
      .o_addr   (w_slot_addr[k])
    );
  end

  // At most one slot passes a non-zero address, so OR-reduction is the mux.
  always_comb begin
    w_sel_addr = '0;
    for (int k = 0; k < N_SRC; k++) w_sel_addr = w_sel_addr | w_slot_addr[k];
  end

  assign w_live = w_hi[N_SRC];
  assign w_adv  = (r_state == S_RUN) & ~i_stall & ~i_halt;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc + STEP;
    case (r_state)
      S_RUN:    if (i_halt)  w_state_nxt = S_HALTED;
      S_HALTED: if (!i_halt) w_state_nxt = S_RUN;
      default:  w_state_nxt = S_RUN;
    endcase
    if (w_live)         w_pc_nxt = w_sel_addr;
    else if (r_pending) w_pc_nxt = r_pend_addr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_PC;
      r_pend_addr   <= '0;
      r_pending     <= 1'b0;
      r_redir_taken <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_adv) begin
        r_pc          <= w_pc_nxt;
        r_redir_taken <= w_live | r_pending;
        r_pending     <= 1'b0;
      end else begin
        // Frozen: park the newest live redirect so it is applied on resume.
        r_redir_taken <= 1'b0;
        if (w_live) begin
          r_pend_addr <= w_sel_addr;
          r_pending   <= 1'b1;
        end
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_pc4         = r_pc + STEP;
  assign o_fetch_en    = (r_state == S_RUN) & ~i_stall;
  assign o_redir_taken = r_redir_taken;
  assign o_pending     = r_pending;
  assign o_halted      = (r_state == S_HALTED);
endmodule

// File: doc/pc_next_ctrl.md
# pc_next_ctrl

Parametrised program-counter unit for the fetch stage. It holds the PC register and picks the next PC from N_SRC prioritised redirect sources or the sequential increment. It buffers a redirect that arrives while the PC is frozen (stall or halt), so the redirect is applied later instead of being lost. It also carries a RUN/HALTED state machine for debug-unit control. It feeds instruction-memory addressing and the IF/ID register.

## Interface
- NB, 32, PC and address width
- N_SRC, 3, number of redirect sources; index 0 = highest priority (e.g. 0 branch, 1 jump, 2 jr/jalr)
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, sequential increment
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_redir_valid  in  N_SRC  per-source redirect request
- i_redir_addr  in  N_SRC*NB  packed targets; source k at bits [k*NB +: NB]
- i_stall  in  1  freeze PC (hazard unit)
- i_halt  in  1  level request to enter/stay HALTED (debug unit)
- o_pc  out  NB  current PC (registered)
- o_pc4  out  NB  o_pc + PC_STEP (combinational, mod 2^NB)
- o_fetch_en  out  1  (state==RUN) & ~i_stall, combinational
- o_redir_taken  out  1  registered; high the cycle o_pc first shows a redirect target
- o_pending  out  1  registered; a buffered redirect is waiting
- o_halted  out  1  state==HALTED

## Operation
- States: RUN, HALTED. Reset → RUN.
- Live select: the lowest index k with i_redir_valid[k]=1 gives sel_addr. live_any = |i_redir_valid.
- Advance condition: state==RUN & ~i_stall & ~i_halt.
- When advancing, next PC has this priority:
  1. live_any → sel_addr
  2. pending → pend_addr
  3. otherwise o_pc + PC_STEP
- Any load from live or pending sets o_redir_taken=1 for the next cycle and clears pending.
- When not advancing (stall, halt, or HALTED):
  - o_pc holds.
  - If live_any, pend_addr ← sel_addr and pending ← 1. A newer capture overwrites an older pending value.
  - Otherwise pending holds.
  - o_redir_taken ← 0.
- State transitions:
  - RUN → HALTED on an edge with i_halt=1. The PC does not advance on that edge.
  - HALTED → RUN on an edge with i_halt=0. The PC does not advance on that edge either; it advances from the following edge.
- i_stall and i_halt together: halt governs the state transition; the PC holds.
- Arithmetic: increment wraps modulo 2^NB. Redirect addresses are used unmodified; there is no alignment check.

## Timing
- Reset values (asynchronous, while i_rst_n=0):
  - o_pc=RESET_PC, o_pc4=RESET_PC+PC_STEP
  - o_redir_taken=0, o_pending=0, o_halted=0
  - pend_addr=0, state=RUN
  - o_fetch_en = ~i_stall
- Reset asserted mid-operation discards pending and halt state immediately.
- Latency: a redirect presented in cycle t with the advance condition true appears on o_pc in cycle t+1, with o_redir_taken=1 in t+1.
- A buffered redirect appears on o_pc one cycle after the first cycle in which the advance condition is true.
- Redirect requests are single-cycle qualified: a request is consumed or buffered in its cycle. The source need not hold it.
- o_pending rises the cycle after the capture and falls the cycle after the pending redirect is applied.

## Test plan
1. Sequential + wrap:
   - Release reset with RESET_PC=0 and no requests → o_pc 0, 4, 8, 12; o_redir_taken=0.
   - Force a redirect to 0xFFFFFFFC, then run with no requests → o_pc goes 0x0 on the following edge.
2. Priority:
   - Same cycle: valid=3'b111 with addrs {0x300, 0x200, 0x100} (src0=0x100) → o_pc=0x100 next cycle; o_redir_taken=1 for exactly one cycle.
   - valid=3'b110 → o_pc=0x200.
3. Redirect during stall:
   - i_stall=1 for 3 cycles, src2 redirect to 0x80 in the 1st stall cycle → o_pc holds; o_pending=1 from the 2nd stall cycle.
   - After stall drops: o_pc=0x80, o_redir_taken=1, o_pending=0.
4. Live vs pending:
   - Pending 0x80 buffered; in the first unstalled cycle src1 requests 0x40 → o_pc=0x40; pending cleared; 0x80 never appears.
5. Halt/resume:
   - i_halt=1 at o_pc=0x10 → o_halted=1 next cycle; o_fetch_en=0; o_pc stays 0x10.
   - src0 redirect to 0x500 while halted → o_pending=1.
   - Drop i_halt → RUN after one edge with o_pc=0x10, then o_pc=0x500 with o_redir_taken=1.
6. Async reset mid-halt with pending:
   - Pull i_rst_n low off-edge → immediately o_pc=RESET_PC, o_pending=0, o_halted=0.
   - After release, sequential fetch from RESET_PC.
